sd_data_serial_card: RTL and testbench

- Card-side data-line engine for the SD 4-bit DAT bus; the opposite end of the host data serialiser.
- On a write command it receives one host block, checks the per-line CRC16, returns the CRC status token and holds busy.
- On a read command it sends one block with start bit, data, per-line CRC16 and end bit.
- Used as the card model in host-data benches and as the data path of the card emulator.

---
 rtl/sd_data_serial_card.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_sd_data_serial_card.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_data_serial_card.sv
// sd_data_serial_card: card-side engine for the SD 4-bit DAT bus.
// Write: receive one block, check the per-line CRC16, return the CRC status token, hold busy.
// Read: send one block with start bit, data, per-line CRC16 and end bit.
// Optional build macro SD_CARD_RX_TIMEOUT_EN: abandon a write whose start bit never arrives.

`ifndef SD_BUS_W
`define SD_BUS_W 4
`endif

module sd_data_serial_card #(
    parameter int unsigned BLKSIZE     = 512,
    parameter int unsigned BUSY_CYCLES = 8
) (
    input  logic                 sd_clk,
    input  logic                 rst,
    input  logic [`SD_BUS_W-1:0] DAT_dat_i,
    output logic [`SD_BUS_W-1:0] DAT_dat_o,
    output logic                 DAT_oe_o,
    input  logic                 start_rd,
    input  logic                 start_wr,
    input  logic [31:0]          tx_data,
    output logic                 tx_rd,
    output logic [31:0]          rx_data,
    output logic                 rx_we,
    output logic                 busy_n,
    output logic                 blk_done,
    output logic                 crc_err
);

    localparam int unsigned W         = `SD_BUS_W;
    localparam logic [15:0] LAST_NIB  = 16'(2 * BLKSIZE - 1);
    localparam logic [15:0] LAST_BUSY = 16'(BUSY_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StTxPre,
        StTxStart,
        StTxData,
        StTxCrc,
        StTxEnd,
        StRxWait,
        StRxData,
        StRxCrc,
        StRxEnd,
        StRxStat,
        StRxBusy
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [31:0]         tx_sr_q, tx_sr_d;
    logic [31:0]         rx_sr_q, rx_sr_d;
    logic [W-1:0][15:0]  crc_q, crc_d;
    logic [31:0]         rx_data_q, rx_data_d;
    logic                rx_we_q, rx_we_d;
    logic                crc_err_q, crc_err_d;
    logic                blk_done_q, blk_done_d;
    logic [W-1:0]        dat_out;
    logic                oe_out;
    logic                tx_rd_out;
`ifdef SD_CARD_RX_TIMEOUT_EN
    logic [15:0]         tmo_q, tmo_d;
`endif

    // Serial CRC16 (x^16+x^12+x^5+1), one data bit in, MSB first.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Next-state, datapath and line outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        crc_d     = crc_q;
        rx_data_d = rx_data_q;
        rx_we_d   = 1'b0;
        crc_err_d = crc_err_q;
        dat_out   = '1;
        oe_out    = 1'b0;
        tx_rd_out = 1'b0;
`ifdef SD_CARD_RX_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Read wins a simultaneous start; the write request is dropped.
                if (start_rd) begin
                    state_d   = StTxPre;
                    crc_err_d = 1'b0;
                end else if (start_wr) begin
                    state_d   = StRxWait;
                    crc_err_d = 1'b0;
`ifdef SD_CARD_RX_TIMEOUT_EN
                    tmo_d     = 16'd0;
`endif
                end
            end
            StTxPre: begin
                oe_out    = 1'b1;
                tx_rd_out = 1'b1;
                state_d   = StTxStart;
            end
            StTxStart: begin
                oe_out  = 1'b1;
                dat_out = '0;
                tx_sr_d = tx_data;
                cnt_d   = 16'd0;
                crc_d   = '0;
                state_d = StTxData;
            end
            StTxData: begin
                oe_out  = 1'b1;
                dat_out = tx_sr_q[31 -: W];
                for (int i = 0; i < W; i++) begin
                    crc_d[i] = crc16_next(crc_q[i], tx_sr_q[32-W+i]);
                end
                // Last nibble of a word: the next word arrives on this edge, no gap.
                if (cnt_q[2:0] == 3'd7) begin
                    tx_sr_d   = tx_data;
                    tx_rd_out = (cnt_q != LAST_NIB);
                end else begin
                    tx_sr_d = {tx_sr_q[31-W:0], {W{1'b0}}};
                end
                if (cnt_q == LAST_NIB) begin
                    cnt_d   = 16'd0;
                    state_d = StTxCrc;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StTxCrc: begin
                oe_out = 1'b1;
                for (int i = 0; i < W; i++) begin
                    dat_out[i] = crc_q[i][15];
                    crc_d[i]   = {crc_q[i][14:0], 1'b0};
                end
                if (cnt_q == 16'd15) begin
                    cnt_d   = 16'd0;
                    state_d = StTxEnd;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StTxEnd: begin
                oe_out  = 1'b1;
                state_d = StIdle;
            end
            StRxWait: begin
                // The start-bit cycle itself carries no data.
                if (DAT_dat_i == '0) begin
                    state_d = StRxData;
                    cnt_d   = 16'd0;
                    crc_d   = '0;
                end
`ifdef SD_CARD_RX_TIMEOUT_EN
                else if (tmo_q == 16'hFFFE) begin
                    state_d   = StIdle;
                    crc_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            StRxData: begin
                rx_sr_d = {rx_sr_q[31-W:0], DAT_dat_i};
                for (int i = 0; i < W; i++) begin
                    crc_d[i] = crc16_next(crc_q[i], DAT_dat_i[i]);
                end
                if (cnt_q[2:0] == 3'd7) begin
                    rx_data_d = {rx_sr_q[31-W:0], DAT_dat_i};
                    rx_we_d   = 1'b1;
                end
                if (cnt_q == LAST_NIB) begin
                    cnt_d   = 16'd0;
                    state_d = StRxCrc;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRxCrc: begin
                for (int i = 0; i < W; i++) begin
                    if (DAT_dat_i[i] != crc_q[i][15]) begin
                        crc_err_d = 1'b1;
                    end
                    crc_d[i] = {crc_q[i][14:0], 1'b0};
                end
                if (cnt_q == 16'd15) begin
                    cnt_d   = 16'd0;
                    state_d = StRxEnd;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRxEnd: begin
                if (DAT_dat_i != '1) begin
                    crc_err_d = 1'b1;
                end
                cnt_d   = 16'd0;
                state_d = StRxStat;
            end
            StRxStat: begin
                // Two turnaround cycles, then 0,s2,s1,s0,1 on DAT0 (010 ok, 101 error).
                if (cnt_q >= 16'd2) begin
                    oe_out = 1'b1;
                    case (cnt_q[2:0])
                        3'd2:    dat_out[0] = 1'b0;
                        3'd3:    dat_out[0] = crc_err_q;
                        3'd4:    dat_out[0] = ~crc_err_q;
                        3'd5:    dat_out[0] = crc_err_q;
                        default: dat_out[0] = 1'b1;
                    endcase
                end
                if (cnt_q == 16'd6) begin
                    cnt_d   = 16'd0;
                    state_d = StRxBusy;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRxBusy: begin
                oe_out     = 1'b1;
                dat_out[0] = 1'b0;
                if (cnt_q == LAST_BUSY) begin
                    cnt_d   = 16'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // blk_done marks the first IDLE cycle after any transfer.
    always_comb begin
        blk_done_d = (state_q != StIdle) && (state_d == StIdle);
    end

    // State and datapath registers; reset aborts any transfer at once.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 16'd0;
            tx_sr_q    <= 32'd0;
            rx_sr_q    <= 32'd0;
            crc_q      <= '0;
            rx_data_q  <= 32'd0;
            rx_we_q    <= 1'b0;
            crc_err_q  <= 1'b0;
            blk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            crc_q      <= crc_d;
            rx_data_q  <= rx_data_d;
            rx_we_q    <= rx_we_d;
            crc_err_q  <= crc_err_d;
            blk_done_q <= blk_done_d;
        end
    end

`ifdef SD_CARD_RX_TIMEOUT_EN
    // Start-bit wait counter.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            tmo_q <= 16'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign DAT_dat_o = dat_out;
    assign DAT_oe_o  = oe_out;
    assign tx_rd     = tx_rd_out;
    assign rx_data   = rx_data_q;
    assign rx_we     = rx_we_q;
    assign busy_n    = (state_q == StIdle);
    assign blk_done  = blk_done_q;
    assign crc_err   = crc_err_q;

endmodule

// File: tb/tb_sd_data_serial_card.sv
// tb_sd_data_serial_card: transaction-level model of the card DAT engine.
// Each transfer is expanded into a per-cycle list of bus inputs and expected outputs.

module tb_sd_data_serial_card;

    localparam int unsigned BLK   = 512;
    localparam int unsigned NIB   = 2 * BLK;
    localparam int unsigned WORDS = BLK / 4;
    localparam int unsigned BUSY  = 8;

    logic        sd_clk = 1'b0;
    logic        rst;
    logic [3:0]  DAT_dat_i;
    logic [3:0]  DAT_dat_o;
    logic        DAT_oe_o;
    logic        start_rd;
    logic        start_wr;
    logic [31:0] tx_data;
    logic        tx_rd;
    logic [31:0] rx_data;
    logic        rx_we;
    logic        busy_n;
    logic        blk_done;
    logic        crc_err;

    sd_data_serial_card #(
        .BLKSIZE    (BLK),
        .BUSY_CYCLES(BUSY)
    ) dut (
        .sd_clk   (sd_clk),
        .rst      (rst),
        .DAT_dat_i(DAT_dat_i),
        .DAT_dat_o(DAT_dat_o),
        .DAT_oe_o (DAT_oe_o),
        .start_rd (start_rd),
        .start_wr (start_wr),
        .tx_data  (tx_data),
        .tx_rd    (tx_rd),
        .rx_data  (rx_data),
        .rx_we    (rx_we),
        .busy_n   (busy_n),
        .blk_done (blk_done),
        .crc_err  (crc_err)
    );

    always #5 sd_clk = ~sd_clk;

    typedef struct {
        logic        oe;
        logic        chk_dat;
        logic [3:0]  dat;
        logic        busy_n;
        logic        tx_rd;
        logic        rx_we;
        logic [31:0] rx_data;
        logic        blk_done;
        logic        chk_err;
        logic        crc_err;
    } exp_t;

    typedef struct {
        logic       start_rd;
        logic       start_wr;
        logic [3:0] dat;
    } drv_t;

    exp_t        exp_q[$];
    drv_t        drv_q[$];
    logic [31:0] blk_words [WORDS];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tx_idx = 0;
    int          n_txrd = 0;
    int          n_rxwe = 0;
    logic        crc_err_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // CRC16 by polynomial long division of msg(x)*x^16; msg[len-1] is sent first.
    function automatic logic [15:0] crc16_div(input logic [NIB-1:0] msg, input int len);
        logic [16:0] rem;
        rem = '0;
        for (int k = len - 1; k >= -16; k--) begin
            rem = {rem[15:0], (k >= 0) ? msg[k] : 1'b0};
            if (rem[16]) rem = rem ^ 17'h11021;
        end
        return rem[15:0];
    endfunction

    function automatic logic [3:0] nib_at(input int n);
        logic [31:0] w;
        w = blk_words[n / 8];
        return 4'(w >> (28 - 4 * (n % 8)));
    endfunction

    function automatic logic [15:0] line_crc(input int l);
        logic [NIB-1:0] msg;
        logic [3:0]     nb;
        for (int n = 0; n < NIB; n++) begin
            nb = nib_at(n);
            msg[NIB-1-n] = nb[l];
        end
        return crc16_div(msg, NIB);
    endfunction

    function automatic exp_t mk(input logic oe, input logic chk_dat, input logic [3:0] dat,
                                input logic bsy_n, input logic chk_err, input logic err);
        exp_t e;
        e.oe = oe; e.chk_dat = chk_dat; e.dat = dat; e.busy_n = bsy_n;
        e.tx_rd = 1'b0; e.rx_we = 1'b0; e.rx_data = 32'd0; e.blk_done = 1'b0;
        e.chk_err = chk_err; e.crc_err = err;
        return e;
    endfunction

    function automatic drv_t dv(input logic rd, input logic wr, input logic [3:0] dat);
        drv_t d;
        d.start_rd = rd; d.start_wr = wr; d.dat = dat;
        return d;
    endfunction

    // Occasional stray start pulse while the card is busy.
    function automatic logic nz(input int on);
        return (on != 0) && ($urandom_range(0, 39) == 0);
    endfunction

    task automatic push(input exp_t e, input drv_t d);
        exp_q.push_back(e);
        drv_q.push_back(d);
    endtask

    // One cycle: compare outputs at the falling edge, then apply the next inputs.
    task automatic step();
        exp_t e;
        drv_t d;
        @(negedge sd_clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, crc_err_m);
        d = (drv_q.size() > 0) ? drv_q.pop_front() : dv(1'b0, 1'b0, 4'hF);
        check("oe", 32'(DAT_oe_o), 32'(e.oe));
        if (e.chk_dat) check("dat", 32'(DAT_dat_o), 32'(e.dat));
        check("busy_n", 32'(busy_n), 32'(e.busy_n));
        check("tx_rd", 32'(tx_rd), 32'(e.tx_rd));
        check("rx_we", 32'(rx_we), 32'(e.rx_we));
        if (e.rx_we) check("rx_data", rx_data, e.rx_data);
        check("blk_done", 32'(blk_done), 32'(e.blk_done));
        if (e.chk_err) check("crc_err", 32'(crc_err), 32'(e.crc_err));
        if (tx_rd === 1'b1) begin
            n_txrd++;
            tx_data = (tx_idx < int'(WORDS)) ? blk_words[tx_idx] : $urandom();
            tx_idx++;
        end
        if (rx_we === 1'b1) n_rxwe++;
        start_rd  = d.start_rd;
        start_wr  = d.start_wr;
        DAT_dat_i = d.dat;
    endtask

    task automatic run();
        while (exp_q.size() > 0) step();
        repeat (2) step();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_oe"}, 32'(DAT_oe_o), 32'd0);
        check({tag, "_dat"}, 32'(DAT_dat_o), 32'hF);
        check({tag, "_tx_rd"}, 32'(tx_rd), 32'd0);
        check({tag, "_rx_we"}, 32'(rx_we), 32'd0);
        check({tag, "_rx_data"}, rx_data, 32'd0);
        check({tag, "_busy_n"}, 32'(busy_n), 32'd1);
        check({tag, "_blk_done"}, 32'(blk_done), 32'd0);
        check({tag, "_crc_err"}, 32'(crc_err), 32'd0);
    endtask

    // Host writes blk_words; fl/fmask corrupt one line's CRC, endn is the end nibble.
    task automatic build_write(input int gap, input int fl, input logic [15:0] fmask,
                               input logic [3:0] endn, input int noisy);
        logic [15:0] crc [4];
        logic        bad;
        logic [4:0]  tok;
        logic [3:0]  cd;
        exp_t        e;
        for (int l = 0; l < 4; l++) crc[l] = line_crc(l);
        bad = (fmask != 16'd0) || (endn != 4'hF);
        tok = bad ? 5'b01011 : 5'b00101;
        push(mk(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, crc_err_m), dv(1'b0, 1'b1, 4'hF));
        for (int g = 0; g < gap; g++)
            push(mk(1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0), dv(nz(noisy), nz(noisy), 4'hF));
        push(mk(1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0), dv(nz(noisy), nz(noisy), 4'h0));
        for (int n = 0; n < NIB; n++) begin
            e = mk(1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
            if (n >= 8 && n % 8 == 0) begin
                e.rx_we = 1'b1;
                e.rx_data = blk_words[n / 8 - 1];
            end
            push(e, dv(nz(noisy), nz(noisy), nib_at(n)));
        end
        for (int k = 0; k < 16; k++) begin
            for (int l = 0; l < 4; l++)
                cd[l] = crc[l][15-k] ^ ((l == fl) ? fmask[15-k] : 1'b0);
            e = mk(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
            if (k == 0) begin
                e.rx_we = 1'b1;
                e.rx_data = blk_words[WORDS-1];
            end
            push(e, dv(nz(noisy), nz(noisy), cd));
        end
        push(mk(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0), dv(nz(noisy), nz(noisy), endn));
        for (int k = 0; k < 7; k++) begin
            if (k < 2) e = mk(1'b0, 1'b0, 4'hF, 1'b0, 1'b1, bad);
            else       e = mk(1'b1, 1'b1, {3'b111, tok[6-k]}, 1'b0, 1'b1, bad);
            push(e, dv(nz(noisy), nz(noisy), 4'hF));
        end
        for (int k = 0; k < int'(BUSY); k++)
            push(mk(1'b1, 1'b1, 4'hE, 1'b0, 1'b1, bad), dv(nz(noisy), nz(noisy), 4'hF));
        e = mk(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, bad);
        e.blk_done = 1'b1;
        push(e, dv(1'b0, 1'b0, 4'hF));
        crc_err_m = bad;
    endtask

    // Card sends blk_words; `both` raises start_wr together with start_rd.
    task automatic do_read(input logic both, input int noisy);
        logic [15:0] crc [4];
        logic [3:0]  cd;
        exp_t        e;
        for (int l = 0; l < 4; l++) crc[l] = line_crc(l);
        tx_idx = 0;
        n_txrd = 0;
        push(mk(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, crc_err_m), dv(1'b1, both, 4'hF));
        e = mk(1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
        e.tx_rd = 1'b1;
        push(e, dv(1'b0, nz(noisy), 4'hF));
        push(mk(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0), dv(nz(noisy), nz(noisy), 4'hF));
        for (int n = 0; n < NIB; n++) begin
            e = mk(1'b1, 1'b1, nib_at(n), 1'b0, 1'b1, 1'b0);
            e.tx_rd = (n % 8 == 7) && (n != NIB - 1);
            push(e, dv(nz(noisy), nz(noisy), 4'hF));
        end
        for (int k = 0; k < 16; k++) begin
            for (int l = 0; l < 4; l++) cd[l] = crc[l][15-k];
            push(mk(1'b1, 1'b1, cd, 1'b0, 1'b1, 1'b0), dv(nz(noisy), nz(noisy), 4'hF));
        end
        push(mk(1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0), dv(1'b0, 1'b0, 4'hF));
        e = mk(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
        e.blk_done = 1'b1;
        push(e, dv(1'b0, 1'b0, 4'hF));
        crc_err_m = 1'b0;
        run();
        check("tx_rd_count", n_txrd, 32'd128);
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < int'(WORDS); i++)
            blk_words[i] = (mode == 0) ? 32'd0 : (mode == 1) ? 32'h01234567 : $urandom();
    endtask

    task automatic write_full(input int gap, input int fl, input logic [15:0] fmask,
                              input logic [3:0] endn, input int noisy);
        n_rxwe = 0;
        build_write(gap, fl, fmask, endn, noisy);
        run();
        check("rx_we_count", n_rxwe, 32'd128);
    endtask

    initial begin
        logic [NIB-1:0] pin_msg;
        logic [71:0]    ascii;
        exp_t           e;

        rst = 1'b1; start_rd = 1'b0; start_wr = 1'b0; DAT_dat_i = 4'hF; tx_data = 32'd0;
        #3;
        check_reset("por");
        @(negedge sd_clk);
        rst = 1'b0;
        repeat (3) step();

        // Pin the CRC model: XMODEM check value and the all-zero block.
        ascii = "123456789";
        pin_msg = '0;
        pin_msg[71:0] = ascii;
        check("crc_model_check", 32'(crc16_div(pin_msg, 72)), 32'h31C3);
        fill(0);
        check("crc_model_zero", 32'(line_crc(0)), 32'h0000);

        // All-zero write, good CRC, then same write with DAT2 CRC bit 3 flipped.
        write_full(0, 0, 16'h0000, 4'hF, 0);
        write_full(2, 2, 16'h0008, 4'hF, 0);
        repeat (5) step();

        // Read of 01234567 words, then a random read with a colliding start_wr and noise.
        fill(1);
        do_read(1'b0, 0);
        fill(2);
        do_read(1'b1, 1);

        // Random writes: clean with stray starts, bad end nibble, random CRC bit flip.
        fill(2);
        write_full(3, 0, 16'h0000, 4'hF, 1);
        fill(2);
        write_full(0, 0, 16'h0000, 4'hB, 0);
        fill(2);
        write_full(1, int'($urandom_range(0, 3)), 16'(1 << $urandom_range(0, 15)), 4'hF, 0);
        fill(2);
        write_full(1, 0, 16'h0000, 4'hF, 0);

        // Reset in the middle of nibble 300 of a write, then a normal write.
        fill(2);
        build_write(1, 0, 16'h0000, 4'hF, 0);
        repeat (1 + 1 + 1 + 301) step();
        #1 rst = 1'b1;
        #1 check_reset("mid_rst");
        exp_q.delete();
        drv_q.delete();
        start_rd = 1'b0; start_wr = 1'b0; DAT_dat_i = 4'hF;
        crc_err_m = 1'b0;
        repeat (2) @(negedge sd_clk);
        check_reset("rst_held");
        #1 rst = 1'b0;
        repeat (2) step();
        fill(2);
        write_full(2, 0, 16'h0000, 4'hF, 0);

`ifdef SD_CARD_RX_TIMEOUT_EN
        // No start bit ever: timeout, error, no token.
        push(mk(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, crc_err_m), dv(1'b0, 1'b1, 4'hF));
        for (int c = 0; c < 65535; c++)
            push(mk(1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0), dv(1'b0, 1'b0, 4'hF));
        e = mk(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1);
        e.blk_done = 1'b1;
        push(e, dv(1'b0, 1'b0, 4'hF));
        crc_err_m = 1'b1;
        run();
`else
        e = mk(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, crc_err_m);
        exp_q.push_back(e);
        drv_q.push_back(dv(1'b0, 1'b0, 4'hF));
        run();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
